// File: rtl/periph_pkg.sv
// Shared definitions for the peripheral input unit: FSM state encoding and data width.
package periph_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Push-button conditioning: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync_a;
  logic             sync_b;
  logic             level_q;
  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours; the raw button only ever reaches sync_a.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      count   <= '0;
    end else begin
      sync_a  <= button;
      sync_b  <= sync_a;
      level_q <= level;
      if (sync_b == level) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_b;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/peripheral_input_unit.sv
// Responder for the processor's temporary-halt input handshake: holds the halt while the
// user sets switches and presses confirm. Optional wait limit: define PERIPH_TIMEOUT_EN.
module peripheral_input_unit
  import periph_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 100000000
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              halt_request,
  input  logic [SW_WIDTH-1:0] switches,
  input  logic              confirm_button,
  output logic              peripheral_signal,
  output logic [DATA_W-1:0] input_data,
  output logic              input_valid,
  output logic              timeout_flag
);

  state_t state, next_state;
  logic   button_level;
  logic   press;
  logic   latch_press;
  logic   do_timeout;
  logic   timeout_due;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock (clock),
    .rst   (rst),
    .button(confirm_button),
    .level (button_level),
    .rise  (press)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    next_state  = state;
    latch_press = 1'b0;
    do_timeout  = 1'b0;
    unique case (state)
      IDLE: if (halt_request) next_state = ARM;
      ARM: begin
        if (!halt_request) next_state = IDLE;
        else if (timeout_due) begin
          do_timeout = 1'b1;
          next_state = DONE;
        end else if (!button_level) next_state = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        // Abort outranks a coincident press; a press outranks a coincident timeout.
        if (!halt_request) next_state = IDLE;
        else if (press) begin
          latch_press = 1'b1;
          next_state  = DONE;
        end else if (timeout_due) begin
          do_timeout = 1'b1;
          next_state = DONE;
        end
      end
      DONE: if (!halt_request) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      peripheral_signal <= 1'b0;
      input_data        <= '0;
      input_valid       <= 1'b0;
    end else begin
      peripheral_signal <= (next_state == ARM) || (next_state == WAIT_PRESS);
      input_valid       <= latch_press | do_timeout;
      if (latch_press)     input_data <= DATA_W'(switches);
      else if (do_timeout) input_data <= '0;
    end
  end

`ifdef PERIPH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt;
  logic            waiting;

  assign waiting     = (state == ARM) || (state == WAIT_PRESS);
  assign timeout_due = waiting && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
      if (latch_press)     timeout_flag <= 1'b0;
      else if (do_timeout) timeout_flag <= 1'b1;
    end
  end
`else
  // No wait counter in this build: waiting is unbounded.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_due  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_input_unit.sv
// Directed self-checking bench for peripheral_input_unit with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50; the timeout scenario runs when PERIPH_TIMEOUT_EN is defined.
module tb_peripheral_input_unit;

  localparam int SW_WIDTH = 16;
  localparam int DEB      = 4;
  localparam int TMO      = 50;
  localparam int LATENCY  = DEB + 3;  // raw rise -> latch edge

  logic                clock;
  logic                rst;
  logic                halt_request;
  logic [SW_WIDTH-1:0] switches;
  logic                confirm_button;
  logic                peripheral_signal;
  logic [31:0]         input_data;
  logic                input_valid;
  logic                timeout_flag;

  int checks;
  int errors;
  int valid_count;

  peripheral_input_unit #(
    .SW_WIDTH       (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock            (clock),
    .rst              (rst),
    .halt_request     (halt_request),
    .switches         (switches),
    .confirm_button   (confirm_button),
    .peripheral_signal(peripheral_signal),
    .input_data       (input_data),
    .input_valid      (input_valid),
    .timeout_flag     (timeout_flag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (input_valid === 1'b1) valid_count <= valid_count + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Raw button has just risen; expect the latch exactly `edges` edges later.
  task automatic expect_latch(input string tag, input int edges, input logic [31:0] exp_data);
    for (int i = 1; i < edges; i++) begin
      step();
      check({tag, "_early_valid"}, 32'(input_valid), 32'd0);
    end
    step();
    check({tag, "_valid"}, 32'(input_valid), 32'd1);
    check({tag, "_data"}, input_data, exp_data);
    check({tag, "_psig_fall"}, 32'(peripheral_signal), 32'd0);
    step();
    check({tag, "_pulse_width"}, 32'(input_valid), 32'd0);
    check({tag, "_data_hold"}, input_data, exp_data);
  endtask

  task automatic finish_handshake();
    halt_request   = 1'b0;
    step();
    confirm_button = 1'b0;
    step(DEB + 6);
  endtask

  int snap;

  initial begin
    checks         = 0;
    errors         = 0;
    valid_count    = 0;
    rst            = 1'b0;
    halt_request   = 1'b0;
    switches       = '0;
    confirm_button = 1'b0;
    step(3);
    rst = 1'b1;

    // Reset release, idle: all outputs stay 0.
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle_outputs", {input_data[28:0], peripheral_signal, input_valid, timeout_flag}, 32'd0);
    end

    // Clean press.
    halt_request = 1'b1;
    switches     = 16'hA5C3;
    check("psig_before_edge", 32'(peripheral_signal), 32'd0);
    step();
    check("psig_one_cycle", 32'(peripheral_signal), 32'd1);
    step();
    confirm_button = 1'b1;
    expect_latch("clean", LATENCY, 32'h0000_A5C3);
    finish_handshake();
    check("clean_psig_idle", 32'(peripheral_signal), 32'd0);

    // Bouncing button: 12 cycles of 2-cycle toggles, then held high.
    snap         = valid_count;
    halt_request = 1'b1;
    switches     = 16'h1234;
    step(2);
    for (int i = 0; i < 6; i++) begin
      confirm_button = ~confirm_button;
      step(2);
    end
    check("bounce_no_valid", 32'(valid_count - snap), 32'd0);
    confirm_button = 1'b1;
    expect_latch("bounce", LATENCY, 32'h0000_1234);
    step(5);
    check("bounce_single", 32'(valid_count - snap), 32'd1);
    finish_handshake();

    // Button already held when the halt arrives.
    confirm_button = 1'b1;
    step(DEB + 6);
    snap         = valid_count;
    halt_request = 1'b1;
    switches     = 16'h00FF;
    step(15);
    check("held_no_latch", 32'(valid_count - snap), 32'd0);
    check("held_psig", 32'(peripheral_signal), 32'd1);
    confirm_button = 1'b0;
    step(DEB + 4);
    check("held_release_no_latch", 32'(valid_count - snap), 32'd0);
    confirm_button = 1'b1;
    expect_latch("held", LATENCY, 32'h0000_00FF);
    check("held_single", 32'(valid_count - snap), 32'd1);
    finish_handshake();

    // Abort in WAIT_PRESS, then press while idle.
    snap         = valid_count;
    halt_request = 1'b1;
    switches     = 16'hFFFF;
    step(3);
    halt_request = 1'b0;
    step();
    check("abort_psig", 32'(peripheral_signal), 32'd0);
    confirm_button = 1'b1;
    step(DEB + 6);
    check("abort_no_valid", 32'(valid_count - snap), 32'd0);
    check("abort_data_kept", input_data, 32'h0000_00FF);
    check("abort_psig_idle", 32'(peripheral_signal), 32'd0);
    confirm_button = 1'b0;
    step(DEB + 6);

    // Press edge coinciding with halt fall: abort wins.
    snap         = valid_count;
    halt_request = 1'b1;
    step(2);
    confirm_button = 1'b1;
    step(LATENCY - 1);
    halt_request = 1'b0;
    step();
    check("coincide_no_valid", 32'(input_valid), 32'd0);
    step(3);
    check("coincide_none", 32'(valid_count - snap), 32'd0);
    check("coincide_data_kept", input_data, 32'h0000_00FF);
    confirm_button = 1'b0;
    step(DEB + 6);

    // Reset mid-wait: outputs drop without a clock edge.
    halt_request = 1'b1;
    step(5);
    check("rstwait_psig_before", 32'(peripheral_signal), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstwait_async_outputs", {input_data[28:0], peripheral_signal, input_valid, timeout_flag}, 32'd0);
    halt_request = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    check("rstwait_after_release", 32'(peripheral_signal), 32'd0);

`ifdef PERIPH_TIMEOUT_EN
    // No press: wait limit releases the halt with zero data.
    halt_request = 1'b1;
    expect_latch("timeout", TMO + 1, 32'd0);
    check("timeout_flag_set", 32'(timeout_flag), 32'd1);
    halt_request = 1'b0;
    step();
    check("timeout_flag_sticky", 32'(timeout_flag), 32'd1);
    halt_request = 1'b1;
    switches     = 16'h5A5A;
    step(2);
    confirm_button = 1'b1;
    expect_latch("after_timeout", LATENCY, 32'h0000_5A5A);
    check("timeout_flag_cleared", 32'(timeout_flag), 32'd0);
    finish_handshake();
`else
    // No wait limit: a long wait neither releases nor flags.
    snap         = valid_count;
    halt_request = 1'b1;
    step(TMO + 10);
    check("nolimit_no_valid", 32'(valid_count - snap), 32'd0);
    check("nolimit_psig", 32'(peripheral_signal), 32'd1);
    check("nolimit_flag", 32'(timeout_flag), 32'd0);
    finish_handshake();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
